// File: rtl/slave_store_rmw.sv
// Sub-word store engine: read-modify-write of one memory word per request.
// Define STORE_MISALIGN_ERR_EN to reject misaligned/oversize requests through the ERR state.
module slave_store_rmw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              err
);

    localparam int         NB      = DATA_W / 8;
    localparam int         OFF_W   = $clog2(NB);
    localparam logic [2:0] FULL_SZ = 3'(OFF_W);

    // IDLE accept | RD one-cycle read | WAIT await rvalid | WR merged write | ERR reject pulse
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3
`ifdef STORE_MISALIGN_ERR_EN
        , ST_ERR = 3'd4
`endif
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-OFF_W-1:0]  waddr_q;
    logic [OFF_W-1:0]         off_q;
    logic [2:0]               size_q;
    logic [DATA_W-1:0]        wdata_q;
    logic [DATA_W-1:0]        word_q;

    logic                     accept;
    logic [2:0]               sz_eff;
    logic [OFF_W-1:0]         off_raw;
    logic [OFF_W-1:0]         lane_mask;
    logic [OFF_W-1:0]         off_eff;
    logic                     is_full;
    logic [31:0]              lo;
    logic [31:0]              hi;
    logic [NB-1:0]            be;
    logic [DATA_W-1:0]        bit_mask;
    logic [DATA_W-1:0]        shifted;
    logic [DATA_W-1:0]        merged;

    assign accept  = req_valid && req_ready;
    assign off_raw = req_addr[OFF_W-1:0];
    assign sz_eff  = (req_size > FULL_SZ) ? FULL_SZ : req_size;
    assign is_full = (sz_eff == FULL_SZ);

    // Offset bits below the access size; masked off when misalignment is tolerated.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < OFF_W; i++) begin
            lane_mask[i] = (32'(i) < 32'(sz_eff));
        end
    end

    assign off_eff = off_raw & ~lane_mask;

`ifdef STORE_MISALIGN_ERR_EN
    logic bad_req;
    assign bad_req = (req_size > FULL_SZ) || (|(off_raw & lane_mask));
`endif

    always_comb begin
        lo       = 32'(off_q);
        hi       = lo + (32'd1 << size_q);
        be       = '0;
        bit_mask = '0;
        for (int i = 0; i < NB; i++) begin
            be[i]              = (32'(i) >= lo) && (32'(i) < hi);
            bit_mask[8*i +: 8] = {8{be[i]}};
        end
        shifted = wdata_q << {off_q, 3'b000};
        merged  = (shifted & bit_mask) | (mem_rdata & ~bit_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_full) state_d = ST_WR;
                    else         state_d = ST_RD;
`ifdef STORE_MISALIGN_ERR_EN
                    if (bad_req) state_d = ST_ERR;
`endif
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: if (mem_rvalid) state_d = ST_WR;
            ST_WR:   state_d = ST_IDLE;
`ifdef STORE_MISALIGN_ERR_EN
            ST_ERR:  state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_RD: begin
                mem_re   = 1'b1;
                mem_addr = {waddr_q, {OFF_W{1'b0}}};
            end
            ST_WAIT: mem_addr = {waddr_q, {OFF_W{1'b0}}};
            ST_WR: begin
                mem_we    = 1'b1;
                done      = 1'b1;
                mem_addr  = {waddr_q, {OFF_W{1'b0}}};
                mem_wdata = word_q;
            end
`ifdef STORE_MISALIGN_ERR_EN
            ST_ERR:  err = 1'b1;
`endif
            default: ;
        endcase
    end

    // word_q starts as the store data so the full-word path needs no merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            if (accept) begin
                waddr_q <= req_addr[ADDR_W-1:OFF_W];
                off_q   <= off_eff;
                size_q  <= sz_eff;
                wdata_q <= req_wdata;
                word_q  <= req_wdata;
            end
            if (state_q == ST_WAIT && mem_rvalid) begin
                word_q <= merged;
            end
        end
    end

endmodule
